// File: rtl/gb_int_pkg.sv
// gb_int_pkg: interrupt bit indices, dispatch vectors and dispatch FSM states
package gb_int_pkg;
    localparam int VBLANK   = 0;
    localparam int LCD_STAT = 1;
    localparam int TIMER    = 2;
    localparam int SERIAL   = 3;
    localparam int JOYPAD   = 4;
    localparam logic [7:0] VEC_VBLANK   = 8'h40;
    localparam logic [7:0] VEC_LCD_STAT = 8'h48;
    localparam logic [7:0] VEC_TIMER    = 8'h50;
    localparam logic [7:0] VEC_SERIAL   = 8'h58;
    localparam logic [7:0] VEC_JOYPAD   = 8'h60;
    typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP} state_t;
endpackage

// File: rtl/int_priority_enc.sv
// int_priority_enc: fixed-priority (lowest bit wins) encoder for pending interrupts
// Ports: i_pend pending mask; o_onehot winner; o_index winner bit; o_vector dispatch address low byte; o_valid any pending
module int_priority_enc
    import gb_int_pkg::*;
(
    input  logic [4:0] i_pend,
    output logic [4:0] o_onehot,
    output logic [2:0] o_index,
    output logic [7:0] o_vector,
    output logic       o_valid
);
    always_comb begin
        o_valid  = |i_pend;
        o_index  = i_pend[VBLANK]   ? 3'(VBLANK)   :
                   i_pend[LCD_STAT] ? 3'(LCD_STAT) :
                   i_pend[TIMER]    ? 3'(TIMER)    :
                   i_pend[SERIAL]   ? 3'(SERIAL)   :
                   i_pend[JOYPAD]   ? 3'(JOYPAD)   : 3'd0;
        o_onehot = o_valid ? (5'd1 << o_index) : 5'd0;
        o_vector = (o_index == 3'(LCD_STAT)) ? VEC_LCD_STAT :
                   (o_index == 3'(TIMER))    ? VEC_TIMER    :
                   (o_index == 3'(SERIAL))   ? VEC_SERIAL   :
                   (o_index == 3'(JOYPAD))   ? VEC_JOYPAD   : VEC_VBLANK;
    end
endmodule

// File: rtl/interrupt_dispatch.sv
// interrupt_dispatch: IME owner and IF&IE -> push PC / jump-to-vector sequencer
// Inputs: I_CLOCK/I_RESET (sync, active-high), I_IF/I_IE, I_INSTR_BOUNDARY, I_EI/I_DI/I_RETI strobes, I_HALT, I_PC/I_SP.
// Outputs (all registered): bus request + memory write port, PC/SP load, IF clear mask, IME, HALT wake pulse.
// Build option: define INT_EI_DELAY_EN to delay EI's effect until after the next instruction boundary.
module interrupt_dispatch
    import gb_int_pkg::*;
(
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic [4:0]  I_IF,
    input  logic [4:0]  I_IE,
    input  logic        I_INSTR_BOUNDARY,
    input  logic        I_EI,
    input  logic        I_DI,
    input  logic        I_RETI,
    input  logic        I_HALT,
    input  logic [15:0] I_PC,
    input  logic [15:0] I_SP,
    output logic        O_BUS_REQ,
    output logic [15:0] O_MEM_ADDR,
    output logic [7:0]  O_MEM_DATA,
    output logic        O_MEM_WE_L,
    output logic [15:0] O_PC,
    output logic        O_PC_LOAD,
    output logic [15:0] O_SP,
    output logic        O_SP_LOAD,
    output logic [4:0]  O_IF_CLR,
    output logic        O_IME,
    output logic        O_HALT_EXIT
);
    state_t      r_state, w_next;
    logic [4:0]  w_pend, w_onehot;
    logic [2:0]  w_index;
    logic [7:0]  w_vector, r_vec;
    logic        w_valid, w_start, w_wake, r_wake_q, r_ime;
    logic [15:0] r_pc, r_sp;
`ifdef INT_EI_DELAY_EN
    logic        r_arm;
`endif

    assign w_pend  = I_IF & I_IE;
    assign w_start = (r_state == IDLE) && r_ime && w_valid && I_INSTR_BOUNDARY;
    assign w_wake  = I_HALT && w_valid;
    assign O_IME   = r_ime;

    int_priority_enc u_enc (
        .i_pend   (w_pend),
        .o_onehot (w_onehot),
        .o_index  (w_index),
        .o_vector (w_vector),
        .o_valid  (w_valid)
    );

    // Encoder self-consistency: the one-hot winner must match the reported index
    always_comb if (w_valid) assert (w_onehot == (5'd1 << w_index));

    always_ff @(posedge I_CLOCK) r_state <= I_RESET ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? WAIT1 : IDLE;
            WAIT1:   w_next = WAIT2;
            WAIT2:   w_next = PUSH_HI;
            PUSH_HI: w_next = PUSH_LO;
            PUSH_LO: w_next = JUMP;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with the state it belongs to
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            O_BUS_REQ   <= 1'b0;
            O_MEM_ADDR  <= 16'h0000;
            O_MEM_DATA  <= 8'h00;
            O_MEM_WE_L  <= 1'b1;
            O_PC        <= 16'h0000;
            O_PC_LOAD   <= 1'b0;
            O_SP        <= 16'h0000;
            O_SP_LOAD   <= 1'b0;
            O_IF_CLR    <= 5'd0;
            O_HALT_EXIT <= 1'b0;
            r_wake_q    <= 1'b0;
            r_ime       <= 1'b0;
            r_vec       <= 8'h00;
            r_pc        <= 16'h0000;
            r_sp        <= 16'h0000;
`ifdef INT_EI_DELAY_EN
            r_arm       <= 1'b0;
`endif
        end else begin
            if (w_start) begin
                r_vec <= w_vector;
                r_pc  <= I_PC;
                r_sp  <= I_SP;
            end
            O_BUS_REQ   <= w_next != IDLE;
            O_IF_CLR    <= (w_next == WAIT1) ? w_onehot : 5'd0;
            O_MEM_WE_L  <= !(w_next == PUSH_HI || w_next == PUSH_LO);
            O_MEM_ADDR  <= (w_next == PUSH_HI) ? r_sp - 16'd1 : (w_next == PUSH_LO) ? r_sp - 16'd2 : 16'h0000;
            O_MEM_DATA  <= (w_next == PUSH_HI) ? r_pc[15:8] : (w_next == PUSH_LO) ? r_pc[7:0] : 8'h00;
            O_PC        <= (w_next == JUMP) ? {8'h00, r_vec} : 16'h0000;
            O_PC_LOAD   <= w_next == JUMP;
            O_SP        <= (w_next == JUMP) ? r_sp - 16'd2 : 16'h0000;
            O_SP_LOAD   <= w_next == JUMP;
            // Wake only on the rising edge of halted-with-pending so a held condition pulses once
            r_wake_q    <= w_wake;
            O_HALT_EXIT <= w_wake && !r_wake_q;
            if (w_start) begin
                r_ime <= 1'b0;
`ifdef INT_EI_DELAY_EN
                r_arm <= 1'b0;
`endif
            end else if (r_state == IDLE) begin
                if (I_DI) r_ime <= 1'b0;
                else if (I_RETI) r_ime <= 1'b1;
`ifdef INT_EI_DELAY_EN
                else if (!I_EI && r_arm && I_INSTR_BOUNDARY) r_ime <= 1'b1;
                r_arm <= !I_DI && !I_RETI && (I_EI || (r_arm && !I_INSTR_BOUNDARY));
`else
                else if (I_EI) r_ime <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_interrupt_dispatch.sv
// tb_interrupt_dispatch: directed self-checking bench for interrupt_dispatch
module tb_interrupt_dispatch;
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  iif = 5'd0, iie = 5'd0;
    logic        bnd = 1'b0, ei = 1'b0, di = 1'b0, reti = 1'b0, hlt = 1'b0;
    logic [15:0] ipc = 16'h0000, isp = 16'h0000;
    logic        bus_req, we_l, pc_load, sp_load, ime, halt_exit;
    logic [15:0] mem_addr, opc, osp;
    logic [7:0]  mem_data;
    logic [4:0]  if_clr;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    interrupt_dispatch dut (
        .I_CLOCK(clk), .I_RESET(rst), .I_IF(iif), .I_IE(iie), .I_INSTR_BOUNDARY(bnd),
        .I_EI(ei), .I_DI(di), .I_RETI(reti), .I_HALT(hlt), .I_PC(ipc), .I_SP(isp),
        .O_BUS_REQ(bus_req), .O_MEM_ADDR(mem_addr), .O_MEM_DATA(mem_data), .O_MEM_WE_L(we_l),
        .O_PC(opc), .O_PC_LOAD(pc_load), .O_SP(osp), .O_SP_LOAD(sp_load),
        .O_IF_CLR(if_clr), .O_IME(ime), .O_HALT_EXIT(halt_exit)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step; step;
        checks++; if (ime !== 1'b0) begin failures++; $display("FAIL reset_ime: got %b want 0", ime); end
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        checks++; if (we_l !== 1'b1) begin failures++; $display("FAIL reset_we_l: got %b want 1", we_l); end
        checks++; if ({mem_addr, mem_data} !== 24'h0) begin failures++; $display("FAIL reset_mem: got %h want 000000", {mem_addr, mem_data}); end
        checks++; if ({opc, pc_load, osp, sp_load} !== 34'h0) begin failures++; $display("FAIL reset_pc_sp: got %h want 0", {opc, pc_load, osp, sp_load}); end
        checks++; if ({if_clr, halt_exit} !== 6'h0) begin failures++; $display("FAIL reset_ifclr_halt: got %h want 00", {if_clr, halt_exit}); end
        rst = 1'b0;
        step;
    endtask

    task automatic enable_ime;
        iif = 5'd0;
        ei = 1'b1;
        step;
        ei = 1'b0;
`ifdef INT_EI_DELAY_EN
        bnd = 1'b1;
        step;
        bnd = 1'b0;
`endif
        checks++; if (ime !== 1'b1) begin failures++; $display("FAIL enable_ime: got %b want 1", ime); end
    endtask

    task automatic dispatch(input string nm, input logic [4:0] f, e, input logic [15:0] pc, sp,
                            input logic [4:0] f2, exp_clr, input logic [15:0] a_hi, input logic [7:0] d_hi,
                            input logic [15:0] a_lo, input logic [7:0] d_lo, input logic [15:0] e_pc, e_sp);
        iif = f; iie = e; ipc = pc; isp = sp; bnd = 1'b1;
        step;
        bnd = 1'b0; ipc = 16'hDEAD; isp = 16'hBEEF;
        checks++; if ({bus_req, if_clr, ime} !== {1'b1, exp_clr, 1'b0}) begin failures++; $display("FAIL %s_wait1 bus/clr/ime: got %h want %h", nm, {bus_req, if_clr, ime}, {1'b1, exp_clr, 1'b0}); end
        step;
        checks++; if ({bus_req, if_clr, we_l} !== {1'b1, 5'd0, 1'b1}) begin failures++; $display("FAIL %s_wait2 bus/clr/we_l: got %h want %h", nm, {bus_req, if_clr, we_l}, {1'b1, 5'd0, 1'b1}); end
        iif = f2;
        step;
        checks++; if ({we_l, mem_addr, mem_data} !== {1'b0, a_hi, d_hi}) begin failures++; $display("FAIL %s_push_hi we/addr/data: got %h want %h", nm, {we_l, mem_addr, mem_data}, {1'b0, a_hi, d_hi}); end
        step;
        checks++; if ({we_l, mem_addr, mem_data} !== {1'b0, a_lo, d_lo}) begin failures++; $display("FAIL %s_push_lo we/addr/data: got %h want %h", nm, {we_l, mem_addr, mem_data}, {1'b0, a_lo, d_lo}); end
        step;
        checks++; if ({bus_req, we_l, pc_load, opc, sp_load, osp} !== {3'b111, e_pc, 1'b1, e_sp}) begin failures++; $display("FAIL %s_jump: got %h want %h", nm, {bus_req, we_l, pc_load, opc, sp_load, osp}, {3'b111, e_pc, 1'b1, e_sp}); end
        step;
        checks++; if ({bus_req, pc_load, sp_load} !== 3'b000) begin failures++; $display("FAIL %s_release: got %b want 000", nm, {bus_req, pc_load, sp_load}); end
        iif = 5'd0;
    endtask

    task automatic test_dispatch;
        enable_ime;
        dispatch("basic", 5'h05, 5'h1F, 16'h1234, 16'hFFFE, 5'h04, 5'h01,
                 16'hFFFD, 8'h12, 16'hFFFC, 8'h34, 16'h0040, 16'hFFFC);
    endtask

    task automatic test_halt;
        int pulses = 0, busy = 0;
        hlt = 1'b1; iif = 5'h04; iie = 5'h04;
        step;
        checks++; if (halt_exit !== 1'b1) begin failures++; $display("FAIL halt_first: got %b want 1", halt_exit); end
        pulses += int'(halt_exit); busy += int'(bus_req);
        for (int i = 0; i < 4; i++) begin
            step;
            pulses += int'(halt_exit); busy += int'(bus_req);
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL halt_pulses: got %0d want 1", pulses); end
        checks++; if (busy != 0) begin failures++; $display("FAIL halt_bus_req: got %0d want 0", busy); end
        hlt = 1'b0; iif = 5'd0;
        step;
    endtask

    task automatic test_sp_wrap;
        enable_ime;
        dispatch("sp_wrap", 5'h10, 5'h10, 16'hABCD, 16'h0001, 5'h00, 5'h10,
                 16'h0000, 8'hAB, 16'hFFFF, 8'hCD, 16'h0060, 16'hFFFF);
    endtask

    task automatic test_ei_delay;
        iif = 5'h02; iie = 5'h02;
        ei = 1'b1;
        step;
        ei = 1'b0;
`ifdef INT_EI_DELAY_EN
        checks++; if (ime !== 1'b0) begin failures++; $display("FAIL ei_armed_ime: got %b want 0", ime); end
        bnd = 1'b1;
        step;
        bnd = 1'b0;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL ei_first_boundary_bus: got %b want 0", bus_req); end
`endif
        checks++; if (ime !== 1'b1) begin failures++; $display("FAIL ei_ime: got %b want 1", ime); end
        dispatch("ei", 5'h02, 5'h02, 16'h0150, 16'hC000, 5'h00, 5'h02,
                 16'hBFFF, 8'h01, 16'hBFFE, 8'h50, 16'h0048, 16'hBFFE);
    endtask

    task automatic test_ei_di;
        iif = 5'd0;
        ei = 1'b1; di = 1'b1;
        step;
        ei = 1'b0; di = 1'b0;
        checks++; if (ime !== 1'b0) begin failures++; $display("FAIL ei_di_same: got %b want 0", ime); end
        bnd = 1'b1;
        step;
        bnd = 1'b0;
        checks++; if (ime !== 1'b0) begin failures++; $display("FAIL ei_di_after_boundary: got %b want 0", ime); end
        reti = 1'b1;
        step;
        reti = 1'b0;
        checks++; if (ime !== 1'b1) begin failures++; $display("FAIL reti_sets: got %b want 1", ime); end
        di = 1'b1;
        step;
        di = 1'b0;
        checks++; if (ime !== 1'b0) begin failures++; $display("FAIL di_clears: got %b want 0", ime); end
    endtask

    task automatic test_if_change;
        enable_ime;
        dispatch("if_change", 5'h08, 5'h1F, 16'h2000, 16'hD000, 5'h01, 5'h08,
                 16'hCFFF, 8'h20, 16'hCFFE, 8'h00, 16'h0058, 16'hCFFE);
    endtask

    task automatic test_reset_mid;
        int act = 0;
        enable_ime;
        iif = 5'h01; iie = 5'h01; ipc = 16'h1234; isp = 16'hFFFE; bnd = 1'b1;
        step;
        bnd = 1'b0;
        step; step;
        checks++; if ({we_l, mem_addr} !== {1'b0, 16'hFFFD}) begin failures++; $display("FAIL mid_push_hi: got %h want 0fffd", {we_l, mem_addr}); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++; if ({bus_req, we_l, ime, pc_load, mem_addr} !== {4'b0100, 16'h0000}) begin failures++; $display("FAIL mid_reset_outputs: got %h want %h", {bus_req, we_l, ime, pc_load, mem_addr}, {4'b0100, 16'h0000}); end
        for (int i = 0; i < 4; i++) begin
            step;
            act += int'(bus_req) + int'(!we_l) + int'(pc_load);
        end
        checks++; if (act != 0) begin failures++; $display("FAIL mid_reset_idle: got %0d activity want 0", act); end
        iif = 5'd0;
    endtask

    initial begin
        test_reset;
        test_dispatch;
        test_halt;
        test_sp_wrap;
        test_ei_delay;
        test_ei_di;
        test_if_change;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_dispatch.md
# interrupt_dispatch

Sequencer that turns pending Game Boy interrupts into a CPU dispatch. Sits between the IF/IE register logic and the CPU core. Owns the IME master-enable flag, arbitrates IF&IE by fixed priority, and takes the memory bus to push PC. It then loads the vector, clears the serviced IF bit, and wakes the CPU from HALT.

## Interface
Parameters:
- NONE. Vectors, bit indices and states are fixed constants in the shared package.

Ports:
- I_CLOCK  in  1  system clock; one state per rising edge.
- I_RESET  in  1  reset; the block uses one clock, and reset is synchronous and active-high.
- I_IF  in  5  current IF register (bit0 VBLANK … bit4 JOYPAD).
- I_IE  in  5  current IE register.
- I_INSTR_BOUNDARY  in  1  CPU is at an opcode-fetch boundary; dispatch may start only here.
- I_EI / I_DI / I_RETI  in  1 each  one-cycle strobes from the decoder.
- I_HALT  in  1  CPU is halted.
- I_PC  in  16  return address to push.
- I_SP  in  16  current stack pointer.
- O_BUS_REQ  out  1  block owns the memory bus; CPU stalls.
- O_MEM_ADDR  out  16  write address while O_BUS_REQ.
- O_MEM_DATA  out  8  write data.
- O_MEM_WE_L  out  1  active-low write enable.
- O_PC / O_PC_LOAD  out  16 / 1  vector and one-cycle load strobe.
- O_SP / O_SP_LOAD  out  16 / 1  new SP and one-cycle load strobe.
- O_IF_CLR  out  5  one-hot, one-cycle mask of the IF bit to clear.
- O_IME  out  1  master interrupt enable.
- O_HALT_EXIT  out  1  one-cycle wake pulse.

## Operation
- PEND = I_IF & I_IE. The winner is the lowest set bit. The vector is 0x40 + 8·index.
- Dispatch FSM: IDLE → WAIT1 → WAIT2 → PUSH_HI → PUSH_LO → JUMP → IDLE.
- IDLE → WAIT1 when IME=1, PEND≠0 and I_INSTR_BOUNDARY. On that edge, latch the winner one-hot, latch I_PC and latch I_SP, and clear IME.
- WAIT1: O_BUS_REQ=1. O_IF_CLR = latched one-hot.
- WAIT2: O_BUS_REQ=1, no bus activity.
- PUSH_HI: O_MEM_ADDR = SP−1, O_MEM_DATA = PC[15:8], O_MEM_WE_L=0.
- PUSH_LO: O_MEM_ADDR = SP−2, O_MEM_DATA = PC[7:0], O_MEM_WE_L=0.
- JUMP: O_PC = vector with O_PC_LOAD=1. O_SP = SP−2 with O_SP_LOAD=1. O_BUS_REQ drops on the next edge.
- SP arithmetic is 16-bit modulo. For SP=0x0001: PUSH_HI writes 0x0000, PUSH_LO writes 0xFFFF, O_SP=0xFFFF.
- IME: DI clears it next edge. RETI sets it next edge. EI follows the `INT_EI_DELAY_EN` rule. If EI and DI arrive in the same cycle, DI wins. EI/DI/RETI are ignored outside IDLE.
- HALT: if I_HALT and PEND≠0, pulse O_HALT_EXIT one cycle regardless of IME. Dispatch then follows only if IME=1.
- Once IDLE→WAIT1 is taken, new interrupts and IF changes do not alter the latched winner.

## Timing
- Reset values: state IDLE, O_IME=0, O_BUS_REQ=0, O_MEM_WE_L=1, O_MEM_ADDR=0, O_MEM_DATA=0, O_PC=0, O_PC_LOAD=0, O_SP=0, O_SP_LOAD=0, O_IF_CLR=0, O_HALT_EXIT=0.
- Latency from the qualifying boundary edge to O_PC_LOAD is 5 cycles, and O_BUS_REQ is high for exactly those 5 cycles.
- All outputs are registered; the only combinational logic is PEND and the priority encode.
- Reset mid-dispatch: the next edge returns to IDLE with all outputs at reset values. No further writes occur. IF bits not yet cleared stay set.

## Configuration
- `INT_EI_DELAY_EN` defined: EI arms a pending-enable flag. IME becomes 1 on the edge after the next I_INSTR_BOUNDARY, so one instruction executes before any dispatch. DI or RETI cancels the armed flag.
- `INT_EI_DELAY_EN` undefined: EI sets IME on the next edge, with no armed flag.

## Structure
- Package gb_int_pkg holds:
  - bit-index constants VBLANK..JOYPAD;
  - vector constants 0x40/0x48/0x50/0x58/0x60;
  - the FSM state enum IDLE/WAIT1/WAIT2/PUSH_HI/PUSH_LO/JUMP.
- Sub-module int_priority_enc: combinational 5-bit encoder producing a one-hot winner, a 3-bit index, an 8-bit vector and a valid flag.

## Test plan
- IME=1, IF=0x05, IE=0x1F, PC=0x1234, SP=0xFFFE, boundary → O_IF_CLR=0x01. Writes 0x12@0xFFFD and 0x34@0xFFFC. O_PC=0x0040 and O_SP=0xFFFC on the 5th cycle.
- IME=0, I_HALT=1, IF=IE=0x04 → one O_HALT_EXIT pulse, O_BUS_REQ stays 0.
- SP=0x0001, IF=IE=0x10 → writes at 0x0000 and 0xFFFF, O_PC=0x0060, O_SP=0xFFFF.
- EI with IF=IE=0x02 pending, macro defined → no dispatch at the first boundary, dispatch at the second. Macro undefined → dispatch at the first boundary.
- EI and DI in the same cycle → O_IME=0. I_RESET asserted in PUSH_HI → next cycle O_BUS_REQ=0, O_MEM_WE_L=1, state IDLE.
- IF changes 0x08→0x01 during WAIT2 → serviced vector stays 0x0058, O_IF_CLR=0x08.
